scroll_ctrl_v2: RTL and testbench

Parametrised vertical-scroll timing engine for the playfield.
- Advances a wrapping y-offset by a configurable step on each scroll tick while movement is requested.
- Emits a one-cycle tick pulse that drives follower obstacles.
- Keeps a two-digit BCD score and a difficulty level; the level shortens the tick period as the game progresses.
- Sits between the input debounce logic and the obstacle/sprite renderers.

---
 rtl/scroll_ctrl_v2.sv | 165 ++++++++++++++++
 tb/tb_scroll_ctrl_v2.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl_v2.sv
// Vertical-scroll timing engine: wrapping y-offset, follower tick, BCD score and level.
// Optional hi-score register is built when SCROLL_HISCORE_EN is defined.
module scroll_ctrl_v2 #(
  parameter int unsigned BASE_PERIOD = 100000,
  parameter int unsigned PERIOD_DEC  = 10000,
  parameter int unsigned MIN_PERIOD  = 20000,
  parameter int unsigned STEP        = 2,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned SCORE_TICKS = 100,
  parameter int unsigned LEVEL_PTS   = 10,
  parameter int unsigned MAX_LEVEL   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       move_en,
  input  logic       restart,
  output logic [9:0] y_pos,
  output logic       move_followers,
  output logic [7:0] score_bcd,
  output logic [2:0] level,
  output logic       score_wrap
`ifdef SCROLL_HISCORE_EN
  ,
  output logic [7:0] hi_score_bcd
`endif
);

  localparam int unsigned CntW = $clog2(BASE_PERIOD);
  localparam int unsigned SubW = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SubW-1:0] sub_q, sub_d;
  logic [9:0]      y_q, y_d;
  logic [7:0]      score_q, score_d;
  logic [2:0]      level_q, level_d;
  logic            mf_q, mf_d;
  logic            wrap_q, wrap_d;

  logic [31:0] dec;
  logic [31:0] period;
  logic        tick;
  logic        sub_last;
  logic [10:0] y_sum;
  logic [9:0]  y_next;
  logic [3:0]  units_n, tens_n;
  logic        score_roll;
  logic [6:0]  score_bin_n;
  logic        level_up;

  // Period floor computed without letting BASE_PERIOD - dec wrap below zero.
  always_comb begin
    dec = 32'(level_q) * 32'(PERIOD_DEC);
    if (dec < BASE_PERIOD && (BASE_PERIOD - dec) > MIN_PERIOD) begin
      period = BASE_PERIOD - dec;
    end else begin
      period = MIN_PERIOD;
    end
  end

  assign tick     = move_en && (32'(cnt_q) >= (period - 32'd1));
  assign sub_last = (32'(sub_q) == (SCORE_TICKS - 32'd1));

  always_comb begin
    y_sum = 11'(y_q) + 11'(STEP);
    if (32'(y_sum) >= SCREEN_H) begin
      y_next = 10'(32'(y_sum) - SCREEN_H);
    end else begin
      y_next = y_sum[9:0];
    end
  end

  always_comb begin
    score_roll = 1'b0;
    tens_n     = score_q[7:4];
    if (score_q[3:0] == 4'd9) begin
      units_n = 4'd0;
      if (score_q[7:4] == 4'd9) begin
        tens_n     = 4'd0;
        score_roll = 1'b1;
      end else begin
        tens_n = score_q[7:4] + 4'd1;
      end
    end else begin
      units_n = score_q[3:0] + 4'd1;
    end
    score_bin_n = 7'(tens_n) * 7'd10 + 7'(units_n);
    level_up    = (score_bin_n != 7'd0) && ((32'(score_bin_n) % LEVEL_PTS) == 32'd0) &&
                  (32'(level_q) < MAX_LEVEL);
  end

  always_comb begin
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    y_d     = y_q;
    score_d = score_q;
    level_d = level_q;
    mf_d    = 1'b0;
    wrap_d  = 1'b0;
    if (restart) begin
      cnt_d   = '0;
      sub_d   = '0;
      y_d     = '0;
      score_d = '0;
      level_d = '0;
    end else if (tick) begin
      mf_d  = 1'b1;
      cnt_d = '0;
      y_d   = y_next;
      if (sub_last) begin
        sub_d   = '0;
        score_d = {tens_n, units_n};
        wrap_d  = score_roll;
        if (level_up) begin
          level_d = level_q + 3'd1;
        end
      end else begin
        sub_d = sub_q + SubW'(1);
      end
    end else if (move_en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      sub_q   <= '0;
      y_q     <= '0;
      score_q <= '0;
      level_q <= '0;
      mf_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      y_q     <= y_d;
      score_q <= score_d;
      level_q <= level_d;
      mf_q    <= mf_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y_pos          = y_q;
  assign move_followers = mf_q;
  assign score_bcd      = score_q;
  assign level          = level_q;
  assign score_wrap     = wrap_q;

`ifdef SCROLL_HISCORE_EN
  logic [7:0] hi_q;

  // Valid BCD orders the same as binary, so a plain compare suffices.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
    end else if (score_q > hi_q) begin
      hi_q <= score_q;
    end
  end

  assign hi_score_bcd = hi_q;
`endif

endmodule

// File: tb/tb_scroll_ctrl_v2.sv
// Self-checking bench for scroll_ctrl_v2 with a cycle-level behavioural model.
// Hi-score checks are compiled in when SCROLL_HISCORE_EN is defined.
module tb_scroll_ctrl_v2;

  localparam int BASE = 4;
  localparam int DEC  = 1;
  localparam int MINP = 2;
  localparam int STP  = 3;
  localparam int SH   = 10;
  localparam int ST   = 2;
  localparam int LP   = 2;
  localparam int MAXL = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       move_en = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] y_pos;
  logic       move_followers;
  logic [7:0] score_bcd;
  logic [2:0] level;
  logic       score_wrap;
`ifdef SCROLL_HISCORE_EN
  logic [7:0] hi_score_bcd;
`endif

  scroll_ctrl_v2 #(
    .BASE_PERIOD(BASE), .PERIOD_DEC(DEC), .MIN_PERIOD(MINP), .STEP(STP),
    .SCREEN_H(SH), .SCORE_TICKS(ST), .LEVEL_PTS(LP), .MAX_LEVEL(MAXL)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .move_en        (move_en),
    .restart        (restart),
    .y_pos          (y_pos),
    .move_followers (move_followers),
    .score_bcd      (score_bcd),
    .level          (level),
    .score_wrap     (score_wrap)
`ifdef SCROLL_HISCORE_EN
    ,
    .hi_score_bcd   (hi_score_bcd)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: plain integers, score kept in binary.
  int m_cnt = 0, m_y = 0, m_sub = 0, m_score = 0, m_level = 0, m_hi = 0;
  bit m_mf = 0, m_wrap = 0;

  function automatic logic [7:0] to_bcd(input int s);
    logic [3:0] t, u;
    t = 4'(s / 10);
    u = 4'(s % 10);
    return {t, u};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {10'(m_y), m_mf, to_bcd(m_score), 3'(m_level), m_wrap};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {y_pos, move_followers, score_bcd, level, score_wrap};
  endfunction

  task automatic step(input logic me, input logic rs, input logic rn);
    int  p;
    bit  tk;
    move_en = me;
    restart = rs;
    reset_n = rn;
    @(posedge clk);
    if (!rn) begin
      m_cnt = 0; m_y = 0; m_sub = 0; m_score = 0; m_level = 0; m_hi = 0;
      m_mf = 0; m_wrap = 0;
    end else begin
      if (m_score > m_hi) m_hi = m_score;
      if (rs) begin
        m_cnt = 0; m_y = 0; m_sub = 0; m_score = 0; m_level = 0;
        m_mf = 0; m_wrap = 0;
      end else begin
        p = BASE - m_level * DEC;
        if (p < MINP) p = MINP;
        tk = me && (m_cnt >= p - 1);
        m_mf = tk;
        m_wrap = 0;
        if (tk) begin
          m_cnt = 0;
          m_y = (m_y + STP) % SH;
          m_sub++;
          if (m_sub == ST) begin
            m_sub = 0;
            m_score = (m_score + 1) % 100;
            if (m_score == 0) m_wrap = 1;
            else if (m_score % LP == 0 && m_level < MAXL) m_level++;
          end
        end else if (me) begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 1);
      n_cmp++;
      if (dut_vec() !== 23'd0) begin
        n_fail++;
        $display("FAIL idle c=%0d: got %h want 0", c, dut_vec());
      end
    end
  endtask

  task automatic test_scroll_wrap();
    int ys[5] = '{3, 6, 9, 2, 5};
    int np = 0;
    int last = 0;
    step(0, 1, 1);
    for (int c = 1; c <= 60 && np < 5; c++) begin
      step(1, 0, 1);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL scroll_model c=%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (move_followers === 1'b1) begin
        n_cmp++;
        if (y_pos !== 10'(ys[np])) begin
          n_fail++;
          $display("FAIL scroll_y n=%0d: got %0d want %0d", np, y_pos, ys[np]);
        end
        if (np < 4) begin
          n_cmp++;
          if (c - last != 4) begin
            n_fail++;
            $display("FAIL scroll_spacing n=%0d: got %0d want 4", np, c - last);
          end
        end
        last = c;
        np++;
      end
    end
    n_cmp++;
    if (np != 5) begin
      n_fail++;
      $display("FAIL scroll_timeout: got %0d pulses want 5", np);
    end
  endtask

  task automatic test_pause();
    step(0, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 1);
      n_cmp++;
      if (move_followers !== 1'b0 || y_pos !== 10'd0 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause_hold c=%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    step(1, 0, 1);
    n_cmp++;
    if (move_followers !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_resume1: got mf=%b want 0", move_followers);
    end
    step(1, 0, 1);
    n_cmp++;
    if (move_followers !== 1'b1 || y_pos !== 10'd3) begin
      n_fail++;
      $display("FAIL pause_resume2: got mf=%b y=%0d want mf=1 y=3", move_followers, y_pos);
    end
  endtask

  task automatic test_score_level();
    int exp_sp[9] = '{4, 4, 4, 4, 3, 3, 3, 3, 2};
    int exp_sc[9] = '{0, 1, 1, 2, 2, 3, 3, 4, 4};
    int exp_lv[9] = '{0, 0, 0, 1, 1, 1, 1, 2, 2};
    int nt = 0;
    int last = 0;
    step(0, 1, 1);
    for (int c = 1; c <= 100 && nt < 9; c++) begin
      step(1, 0, 1);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL score_model c=%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (move_followers === 1'b1) begin
        n_cmp++;
        if (c - last != exp_sp[nt] || score_bcd !== to_bcd(exp_sc[nt]) ||
            level !== 3'(exp_lv[nt])) begin
          n_fail++;
          $display("FAIL score_tick n=%0d: got sp=%0d sc=%h lv=%0d want sp=%0d sc=%h lv=%0d",
                   nt, c - last, score_bcd, level, exp_sp[nt], to_bcd(exp_sc[nt]),
                   exp_lv[nt]);
        end
        last = c;
        nt++;
      end
    end
    n_cmp++;
    if (nt != 9) begin
      n_fail++;
      $display("FAIL score_timeout: got %0d ticks want 9", nt);
    end
  endtask

  task automatic test_rollover();
    bit seen = 0;
    step(0, 1, 1);
    for (int c = 0; c < 3000 && m_score != 99; c++) begin
      step(1, 0, 1);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL roll_model c=%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (score_bcd !== 8'h99 || level !== 3'd3) begin
      n_fail++;
      $display("FAIL roll_reach99: got sc=%h lv=%0d want 99 lv=3", score_bcd, level);
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1, 0, 1);
      if (score_wrap === 1'b1) begin
        seen = 1;
        n_cmp++;
        if (score_bcd !== 8'h00 || level !== 3'd3) begin
          n_fail++;
          $display("FAIL roll_wrap: got sc=%h lv=%0d want 00 lv=3", score_bcd, level);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL roll_timeout: got no score_wrap want one pulse");
    end
    step(1, 0, 1);
    n_cmp++;
    if (score_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL roll_single: got wrap=%b want 0", score_wrap);
    end
  endtask

  task automatic test_restart();
    step(0, 1, 1);
    for (int c = 0; c < 200 && m_score != 5; c++) step(1, 0, 1);
    step(0, 0, 1);
    n_cmp++;
    if (score_bcd !== 8'h05) begin
      n_fail++;
      $display("FAIL rst_reach5: got %h want 05", score_bcd);
    end
`ifdef SCROLL_HISCORE_EN
    n_cmp++;
    if (hi_score_bcd !== 8'h05) begin
      n_fail++;
      $display("FAIL rst_hi5: got %h want 05", hi_score_bcd);
    end
`endif
    step(0, 1, 1);
    n_cmp++;
    if (y_pos !== 10'd0 || score_bcd !== 8'h00 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_clear: got y=%0d sc=%h lv=%0d want 0", y_pos, score_bcd, level);
    end
`ifdef SCROLL_HISCORE_EN
    n_cmp++;
    if (hi_score_bcd !== 8'h05) begin
      n_fail++;
      $display("FAIL rst_hi_kept: got %h want 05", hi_score_bcd);
    end
`endif
    for (int c = 0; c < 200 && m_score != 3; c++) step(1, 0, 1);
    step(0, 0, 1);
`ifdef SCROLL_HISCORE_EN
    n_cmp++;
    if (hi_score_bcd !== 8'h05) begin
      n_fail++;
      $display("FAIL rst_hi_stay: got %h want 05", hi_score_bcd);
    end
`endif
    step(0, 0, 0);
`ifdef SCROLL_HISCORE_EN
    n_cmp++;
    if (hi_score_bcd !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_hi_reset: got %h want 00", hi_score_bcd);
    end
`endif
    step(0, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 1, 1);
    n_cmp++;
    if (move_followers !== 1'b0 || y_pos !== 10'd0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL rst_vs_tick: got mf=%b y=%0d want mf=0 y=0", move_followers, y_pos);
    end
    step(0, 0, 1);
    n_cmp++;
    if (move_followers !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vs_tick_after: got mf=%b want 0", move_followers);
    end
  endtask

  task automatic test_random();
    logic me, rs, rn;
    for (int c = 0; c < 800; c++) begin
      me = ($urandom_range(0, 9) < 8);
      rs = ($urandom_range(0, 99) == 0);
      rn = ($urandom_range(0, 299) != 0);
      step(me, rs, rn);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
`ifdef SCROLL_HISCORE_EN
      n_cmp++;
      if (hi_score_bcd !== to_bcd(m_hi)) begin
        n_fail++;
        $display("FAIL random_hi c=%0d: got %h want %h", c, hi_score_bcd, to_bcd(m_hi));
      end
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scroll_wrap();
    test_pause();
    test_score_level();
    test_rollover();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
